// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares one single-port on-chip RAM between two PicoRV32-style native
// memory requesters: requester 0 (CPU) and requester 1 (DMA / boot loader).
// Each access walks IDLE -> ISSUE -> DONE, so it takes three cycles. The
// requester's address, write data and strobes are captured on the grant edge.
// Every RAM-side control output and every ready output is registered.
//
// Parameters
//   MEM_WORDS   RAM depth in 32-bit words (power of two)
//   ROUND_ROBIN 1: alternate priority on contention, 0: requester 0 always wins
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   m0_valid/addr/wdata/wstrb    requester 0 request (wstrb == 0 means read)
//   m0_ready, m0_rdata           requester 0 one-cycle completion and read data
//   m1_*                         the same signals for requester 1
//   ram_en                       RAM access strobe (high during ISSUE only)
//   ram_addr/wdata/wstrb         captured word address, write data, byte enables
//   ram_rdata                    RAM read data, valid the cycle after ram_en
//   grant                        one-hot owner of the current access, 00 when idle

module ram_port_arbiter #(
    parameter int MEM_WORDS   = 8192,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                         clk,
    input  logic                         resetn,

    input  logic                         m0_valid,
    input  logic [31:0]                  m0_addr,
    input  logic [31:0]                  m0_wdata,
    input  logic [3:0]                   m0_wstrb,
    output logic                         m0_ready,
    output logic [31:0]                  m0_rdata,

    input  logic                         m1_valid,
    input  logic [31:0]                  m1_addr,
    input  logic [31:0]                  m1_wdata,
    input  logic [3:0]                   m1_wstrb,
    output logic                         m1_ready,
    output logic [31:0]                  m1_rdata,

    output logic                         ram_en,
    output logic [$clog2(MEM_WORDS)-1:0] ram_addr,
    output logic [31:0]                  ram_wdata,
    output logic [3:0]                   ram_wstrb,
    input  logic [31:0]                  ram_rdata,

    output logic [1:0]                   grant
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Index of the requester served most recently; reset to 1 so that
    // requester 0 wins the first tie.
    logic        last_grant;
    // Set when the access in flight addresses beyond the RAM.
    logic        oor_q;

    logic        req_any;
    logic        pick;
    logic [29:0] sel_word;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        sel_oor;

    // Byte-offset bits carry no information for a word-wide RAM.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

    // Winner selection and request mux; only consumed on the grant edge.
    always_comb begin
        req_any = m0_valid | m1_valid;
        if (m0_valid && m1_valid) begin
            pick = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
        end else begin
            pick = m1_valid;
        end
        sel_word  = pick ? m1_addr[31:2] : m0_addr[31:2];
        sel_wdata = pick ? m1_wdata      : m0_wdata;
        sel_wstrb = pick ? m1_wstrb      : m0_wstrb;
        // Compare the full word index so that aliasing addresses are caught.
        sel_oor   = ({2'b00, sel_word} >= 32'(MEM_WORDS));
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs: grant edge captures the request, ISSUE edge turns
    // the strobe into a ready pulse, DONE edge releases the port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_en     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_wstrb  <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            oor_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        // ram_addr keeps the low index bits even when the
                        // access is out of range; only the strobe is withheld.
                        ram_addr   <= sel_word[AW-1:0];
                        ram_wdata  <= sel_wdata;
                        ram_wstrb  <= sel_wstrb;
                        ram_en     <= ~sel_oor;
                        oor_q      <= sel_oor;
                        grant      <= pick ? 2'b10 : 2'b01;
                        last_grant <= pick;
                    end
                end
                ISSUE: begin
                    ram_en   <= 1'b0;
                    m0_ready <= grant[0];
                    m1_ready <= grant[1];
                end
                DONE: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    grant    <= 2'b00;
                end
                default: begin
                    ram_en   <= 1'b0;
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    grant    <= 2'b00;
                end
            endcase
        end
    end

    // Read data steering: only the requester holding ready sees RAM data,
    // and an out-of-range access returns zero instead of stale RAM output.
    always_comb begin
        m0_rdata = '0;
        m1_rdata = '0;
        if (m0_ready && !oor_q) m0_rdata = ram_rdata;
        if (m1_ready && !oor_q) m1_rdata = ram_rdata;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed scenarios followed by randomized
// traffic from two requesters, checked against a transaction-level model.

module tb_ram_port_arbiter;

    localparam int MEM_WORDS = 8192;
    localparam int AW        = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;

    // Requester-side stimulus, index 0 = CPU, 1 = DMA.
    logic        rv [2];
    logic [31:0] ra [2];
    logic [31:0] rd [2];
    logic [3:0]  rs [2];

    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    assign m0_valid = rv[0];
    assign m0_addr  = ra[0];
    assign m0_wdata = rd[0];
    assign m0_wstrb = rs[0];
    assign m1_valid = rv[1];
    assign m1_addr  = ra[1];
    assign m1_wdata = rd[1];
    assign m1_wstrb = rs[1];

    logic          m0_ready, m1_ready;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_wstrb;
    logic [31:0]   ram_rdata;
    logic [1:0]    grant;

    // Fixed-priority instance, fed the same requests.
    logic          f_m0_ready, f_m1_ready;
    logic [31:0]   unused_f_m0_rdata, unused_f_m1_rdata;
    logic          unused_f_ram_en;
    logic [AW-1:0] unused_f_ram_addr;
    logic [31:0]   unused_f_ram_wdata;
    logic [3:0]    unused_f_ram_wstrb;
    logic [31:0]   f_ram_rdata;
    logic [1:0]    f_grant;
    assign f_ram_rdata = 32'h0;

    ram_port_arbiter #(.MEM_WORDS(MEM_WORDS), .ROUND_ROBIN(1)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
        .ram_rdata(ram_rdata), .grant(grant)
    );

    ram_port_arbiter #(.MEM_WORDS(MEM_WORDS), .ROUND_ROBIN(0)) dut_fixed (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(f_m0_ready), .m0_rdata(unused_f_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(f_m1_ready), .m1_rdata(unused_f_m1_rdata),
        .ram_en(unused_f_ram_en), .ram_addr(unused_f_ram_addr), .ram_wdata(unused_f_ram_wdata),
        .ram_wstrb(unused_f_ram_wstrb), .ram_rdata(f_ram_rdata), .grant(f_grant)
    );

    // Synchronous single-port RAM (read-first) with a preload port.
    logic [31:0]   mem [MEM_WORDS];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = AW'(w);
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic req(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        rv[k] = 1'b1;
        ra[k] = a;
        rd[k] = d;
        rs[k] = s;
    endtask

    // One uncontended access issued from an idle negedge; returns at the
    // negedge of the idle cycle that follows completion.
    task automatic run_access(input string tag, input int k, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s, input logic exp_en,
                              input logic [31:0] exp_ra, input logic chk_rd,
                              input logic [31:0] exp_rd);
        logic [1:0] g;
        g = (k == 1) ? 2'b10 : 2'b01;
        req(k, a, d, s);
        @(negedge clk);
        chk({tag, "_en"},    ram_en,    exp_en);
        chk({tag, "_raddr"}, ram_addr,  exp_ra);
        chk({tag, "_wstrb"}, ram_wstrb, s);
        chk({tag, "_wdata"}, ram_wdata, d);
        chk({tag, "_grant"}, grant,     g);
        chk({tag, "_early"}, m0_ready | m1_ready, 1'b0);
        @(negedge clk);
        rv[k] = 1'b0;
        chk({tag, "_rdy0"},  m0_ready, k == 0);
        chk({tag, "_rdy1"},  m1_ready, k == 1);
        chk({tag, "_enoff"}, ram_en,   1'b0);
        chk({tag, "_gdone"}, grant,    g);
        chk({tag, "_other"}, (k == 1) ? m0_rdata : m1_rdata, 32'h0);
        if (chk_rd) chk({tag, "_rdata"}, (k == 1) ? m1_rdata : m0_rdata, exp_rd);
        @(negedge clk);
        chk({tag, "_rdyoff"}, m0_ready | m1_ready, 1'b0);
        chk({tag, "_gidle"},  grant, 2'b00);
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_8000;
        return 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
    endfunction

    // Reference model state (transaction level).
    logic [31:0] ref_mem [64];
    int          ph;
    logic        cur, cur_oor, last;
    logic [31:0] cur_a, cur_d, exp_rd;
    logic [3:0]  cur_s;
    logic        busy [2];

    initial begin
        int          n0, n1, fn0, fn1;
        logic [1:0]  exp_g;
        logic [31:0] got_rd, oth_rd;

        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b0; ra[k] = 32'h0; rd[k] = 32'h0; rs[k] = 4'h0;
        end
        pre_we = 1'b0; pre_addr = '0; pre_data = 32'h0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_en",    ram_en,    1'b0);
        chk("rst_addr",  ram_addr,  32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_wstrb", ram_wstrb, 32'h0);
        chk("rst_rdy",   {m0_ready, m1_ready}, 2'b00);
        chk("rst_grant", grant,     2'b00);

        preload(4, 32'hDEADBEEF);
        preload(9, 32'h11223344);
        preload(0, 32'h5A5A0000);
        resetn = 1'b1;

        run_access("t1_read",  0, 32'h10, 32'h0, 4'h0, 1'b1, 32'd4, 1'b1, 32'hDEADBEEF);
        run_access("t2_bytewr", 1, 32'h24, 32'h000000AB, 4'b0001, 1'b1, 32'd9, 1'b0, 32'h0);
        run_access("t2_rback", 0, 32'h24, 32'h0, 4'h0, 1'b1, 32'd9, 1'b1, 32'h112233AB);
        run_access("t4_oor",   0, 32'h0000_8000, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0, 1'b1, 32'h0);
        run_access("t4_last",  0, 32'h0000_7FFC, 32'hCAFEF00D, 4'hF, 1'b1, 32'h1FFF, 1'b0, 32'h0);
        run_access("t4_rback", 1, 32'h0, 32'h0, 4'h0, 1'b1, 32'd0, 1'b1, 32'h5A5A0000);

        // Contention with both valids held continuously after reset.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        req(0, 32'h10, 32'h0, 4'h0);
        req(1, 32'h24, 32'h0, 4'h0);
        n0 = 0; n1 = 0; fn0 = 0; fn1 = 0;
        for (int i = 1; i <= 12; i++) begin
            int p3, win;
            @(negedge clk);
            p3  = (i - 1) % 3;
            win = ((i - 1) / 3) % 2;
            exp_g = (p3 < 2) ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("t3_rr_grant", grant, exp_g);
            chk("t3_fx_grant", f_grant, (p3 < 2) ? 2'b01 : 2'b00);
            chk("t3_one_rdy",  m0_ready & m1_ready, 1'b0);
            chk("t3_en_rdy",   ram_en & (m0_ready | m1_ready), 1'b0);
            n0  += int'(m0_ready);   n1  += int'(m1_ready);
            fn0 += int'(f_m0_ready); fn1 += int'(f_m1_ready);
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        chk("t3_rr_n0", n0, 2);
        chk("t3_rr_n1", n1, 2);
        chk("t3_fx_n0", fn0, 4);
        chk("t3_fx_n1", fn1, 0);
        repeat (2) @(negedge clk);

        // Reset asserted while the access is in ISSUE.
        req(1, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t5_issue_grant", grant, 2'b10);
        chk("t5_issue_en",    ram_en, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("t5_async_en",    ram_en, 1'b0);
        chk("t5_async_grant", grant,  2'b00);
        chk("t5_async_rdy",   {m0_ready, m1_ready}, 2'b00);
        rv[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_rdy", {m0_ready, m1_ready}, 2'b00);
        end
        resetn = 1'b1;
        req(0, 32'h10, 32'h0, 4'h0);
        req(1, 32'h24, 32'h0, 4'h0);
        @(negedge clk);
        chk("t5_tie_grant", grant, 2'b01);
        rv[0] = 1'b0; rv[1] = 1'b0;
        @(negedge clk);
        chk("t5_tie_rdy0", m0_ready, 1'b1);
        chk("t5_tie_rdy1", m1_ready, 1'b0);
        @(negedge clk);
        chk("t5_tie_gidle", grant, 2'b00);

        // Valid held for one cycle only; inputs scrambled after the grant.
        req(1, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_grant", grant,    2'b10);
        chk("t6_en",    ram_en,   1'b1);
        chk("t6_raddr", ram_addr, 32'h0);
        rv[1] = 1'b0; ra[1] = 32'h7C; rs[1] = 4'hF;
        @(negedge clk);
        chk("t6_rdy",   m1_ready, 1'b1);
        chk("t6_rdata", m1_rdata, 32'h5A5A0000);
        repeat (4) begin
            @(negedge clk);
            chk("t6_quiet", {ram_en, grant, m0_ready, m1_ready}, 5'b0);
        end

        // Randomized traffic against the transaction-level model.
        resetn = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 64; w++) begin
            ref_mem[w] = $urandom;
            preload(w, ref_mem[w]);
        end
        resetn = 1'b1;
        ph = 0; cur = 1'b0; cur_oor = 1'b0; last = 1'b1;
        cur_a = 32'h0; cur_d = 32'h0; cur_s = 4'h0; exp_rd = 32'h0;
        busy[0] = 1'b0; busy[1] = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            exp_g = (ph == 0) ? 2'b00 : (cur ? 2'b10 : 2'b01);
            chk("rnd_grant", grant, exp_g);
            chk("rnd_en",    ram_en, (ph == 1) && !cur_oor);
            chk("rnd_rdy0",  m0_ready, (ph == 2) && !cur);
            chk("rnd_rdy1",  m1_ready, (ph == 2) && cur);
            if (ph == 1) begin
                chk("rnd_raddr", ram_addr,  32'(cur_a[AW+1:2]));
                chk("rnd_wstrb", ram_wstrb, cur_s);
                chk("rnd_wdata", ram_wdata, cur_d);
            end
            if (ph == 2) begin
                got_rd = cur ? m1_rdata : m0_rdata;
                oth_rd = cur ? m0_rdata : m1_rdata;
                chk("rnd_other_rdata", oth_rd, 32'h0);
                if (cur_oor) chk("rnd_oor_rdata", got_rd, 32'h0);
                else if (cur_s == 4'h0) chk("rnd_rdata", got_rd, exp_rd);
            end

            // Requesters: hold valid until ready, sometimes drop or scramble
            // the request right after it has been granted.
            for (int k = 0; k < 2; k++) begin
                if (ph == 2 && int'(cur) == k) begin
                    busy[k] = 1'b0;
                    rv[k]   = 1'b0;
                end else if (!busy[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        busy[k] = 1'b1;
                        rv[k]   = 1'b1;
                        ra[k]   = rnd_addr();
                        rd[k]   = $urandom;
                        rs[k]   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                    end
                end else if (ph == 1 && int'(cur) == k && $urandom_range(0, 3) == 0) begin
                    rv[k] = 1'b0;
                    ra[k] = $urandom;
                    rd[k] = $urandom;
                    rs[k] = 4'($urandom);
                end
            end

            // Access schedule: decision edge, strobe cycle, completion cycle.
            if (ph == 0) begin
                if (rv[0] || rv[1]) begin
                    if (rv[0] && rv[1]) cur = ~last;
                    else                cur = rv[1];
                    last    = cur;
                    cur_a   = ra[int'(cur)];
                    cur_d   = rd[int'(cur)];
                    cur_s   = rs[int'(cur)];
                    cur_oor = (cur_a[31:2] >= 30'(MEM_WORDS));
                    if (!cur_oor) begin
                        exp_rd = ref_mem[cur_a[7:2]];
                        for (int b = 0; b < 4; b++)
                            if (cur_s[b]) ref_mem[cur_a[7:2]][8*b +: 8] = cur_d[8*b +: 8];
                    end
                    ph = 1;
                end
            end else if (ph == 1) begin
                ph = 2;
            end else begin
                ph = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the SoC's single-port on-chip RAM between two PicoRV32-style native-memory requesters.
- Requester 0 is the CPU; requester 1 is a DMA or UART boot loader.
- Sits between the requesters and the RAM array. All RAM-side control outputs are registered.
- Arbitration is round-robin by default, with an optional fixed priority for requester 0.

Parameters:
- MEM_WORDS, 8192: RAM depth in 32-bit words. Must be a power of 2. AW = $clog2(MEM_WORDS).
- ROUND_ROBIN, 1: 1 = alternate priority on contention; 0 = requester 0 always wins.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- m0_valid  in  1  requester 0 request
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_wstrb  in  4  byte write strobes; 0 = read
- m0_ready  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid while m0_ready
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for requester 1
- ram_en  out  1  RAM access strobe
- ram_addr  out  AW  word address
- ram_wdata  out  32  RAM write data
- ram_wstrb  out  4  RAM byte write enables
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en
- grant  out  2  one-hot owner of the current access; 00 when idle

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - ram_en=0, ram_addr=0, ram_wdata=0, ram_wstrb=0.
  - m0_ready=m1_ready=0, grant=00.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset asserted mid-access aborts the access immediately. No ready is issued for it afterwards.
- FSM states: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE:
  - If neither mN_valid is set, remain in IDLE.
  - If exactly one is set, grant it.
  - If both are set:
    - ROUND_ROBIN=1: grant the requester not equal to last_grant.
    - ROUND_ROBIN=0: grant requester 0.
  - On a grant, on the same edge:
    - Latch addr/wdata/wstrb of the winner into the ram_* registers.
    - Set grant and last_grant.
    - Set ram_en=1, or ram_en=0 if the address is out of range (see below).
    - Go to ISSUE.
- ISSUE:
  - ram_en is high for exactly this cycle.
  - Next edge: ram_en<=0, pulse the winner's ready (registered), go to DONE.
- DONE:
  - Winner's mN_ready=1.
  - Winner's mN_rdata=ram_rdata, or 0 if out of range.
  - Non-winner's ready=0 and rdata=0.
  - Next edge: ready<=0, grant<=00, go to IDLE.
- Latency: a request seen in IDLE at edge N gets ram_en during cycle N+1 and ready during cycle N+2. Minimum access is 3 cycles.
- Back-to-back throughput: the next grant can occur on the edge leaving DONE+1, i.e. one access every 3 cycles.
- Contention ordering: a losing requester holding valid is served next. With ROUND_ROBIN=1 and both held continuously, grants strictly alternate 0,1,0,1.
- Out-of-range address: addr[31:2] >= MEM_WORDS.
  - No RAM strobe; the write is dropped.
  - The FSM still traverses ISSUE/DONE.
  - ready pulses with rdata=0.
  - ram_addr takes addr[AW+1:2] regardless.
- Writes: ram_wstrb carries the requester's strobes unchanged. mN_rdata during a write completion is ram_rdata and has no defined meaning.
- Inputs are sampled only at the grant edge. Changes to addr/wdata/wstrb, or a valid drop after the grant, do not affect the access in flight. The access completes and ready still pulses.
- Valid that is still high in IDLE after the requester's own completion is treated as a new request. Requesters must deassert valid after sampling ready, as PicoRV32 does.
- At most one ready output is high in any cycle. ram_en and ready are never high in the same cycle.

Test Plan:
1. Single read: m0_valid, m0_addr=0x10, m0_wstrb=0; RAM word 4 = 0xDEADBEEF.
   -> ram_en in cycle 1 with ram_addr=4; m0_ready in cycle 2 with m0_rdata=0xDEADBEEF; grant=01 during the access.
2. Byte write: m1_valid, m1_addr=0x24, m1_wdata=0x000000AB, m1_wstrb=0001.
   -> ram_addr=9, ram_wstrb=0001, ram_wdata=0x000000AB; then m1_ready for one cycle; m0_ready stays 0.
3. Contention, ROUND_ROBIN=1: both valid held continuously for 12 cycles after reset.
   -> grant sequence 01,10,01,10; four ready pulses alternating m0/m1.
   Contention, ROUND_ROBIN=0: same stimulus -> only m0 served while m0_valid held.
4. Out of range: m0_addr=0x0000_8000, MEM_WORDS=8192, m0_wstrb=1111.
   -> ram_en never asserted; m0_ready pulses in cycle 2 with m0_rdata=0.
5. Reset mid-access: assert resetn=0 during ISSUE.
   -> ram_en, ready and grant go to 0 asynchronously. After release, the first tie goes to m0.
6. Valid dropped after grant: m1_valid high for 1 cycle only, read addr 0x0.
   -> access still completes; m1_ready pulses in cycle 2; no second access follows.
